// File: rtl/binary_to_bcd_digits.sv
// Sequential binary-to-BCD converter (double-dabble, one bit per clock) feeding
// the calculator's seven-segment display decoder with digits and Zero/Overflow flags.
module binary_to_bcd_digits #(
  parameter int WIDTH     = 8,
  parameter int MAX_VALUE = 255
) (
  input  logic             clock,
  input  logic             reset,
  input  logic             start,
  input  logic [WIDTH-1:0] value,
  input  logic             overflow_in,
  output logic             busy,
  output logic             done,
  output logic [3:0]       Units,
  output logic [3:0]       Tens,
  output logic [1:0]       Hundreds,
  output logic             Zero,
  output logic             Overflow,
  output logic             debug_state
);

  // Handshake: start is sampled only while busy=0; the accepting edge raises busy,
  // and WIDTH edges later done pulses for one cycle with the new digits while busy
  // falls. start seen while busy=1 is dropped, never queued. The edge on which done
  // is high can already accept the next start.

  typedef enum logic {
    IDLE  = 1'b0,
    SHIFT = 1'b1
  } state_t;

  localparam logic [9:0] MAX_V = 10'(MAX_VALUE);

  state_t           state;
  state_t           state_next;
  logic [WIDTH-1:0] bin_q;
  logic [9:0]       bcd_q;   // {H[1:0], T[3:0], U[3:0]}
  logic [3:0]       cnt_q;
  logic             ovf_q;

  logic [3:0]       u_adj;
  logic [3:0]       t_adj;
  logic [9:0]       bcd_step;
  logic             last_step;
  logic             final_ovf;

  always_comb begin
    u_adj     = (bcd_q[3:0] >= 4'd5) ? bcd_q[3:0] + 4'd3 : bcd_q[3:0];
    t_adj     = (bcd_q[7:4] >= 4'd5) ? bcd_q[7:4] + 4'd3 : bcd_q[7:4];
    bcd_step  = {bcd_q[8], t_adj, u_adj, bin_q[WIDTH-1]};
    last_step = (state == SHIFT) && (cnt_q == 4'(WIDTH - 1));
    // A hundreds digit of 3+ (or one shifted out of the 2-bit field) is overflow.
    final_ovf = ovf_q | bcd_q[9] | (bcd_step[9:8] == 2'b11);
  end

  // State register
  always_ff @(posedge clock or posedge reset) begin
    if (reset) state <= IDLE;
    else       state <= state_next;
  end

  // Next-state logic
  always_comb begin
    state_next = state;
    case (state)
      IDLE:    if (start)     state_next = SHIFT;
      SHIFT:   if (last_step) state_next = IDLE;
      default:                state_next = IDLE;
    endcase
  end

  // Output logic
  always_comb begin
    busy        = (state == SHIFT);
    debug_state = state;
  end

  // Datapath and registered result; result registers move only on the final step.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      bin_q    <= '0;
      bcd_q    <= '0;
      cnt_q    <= '0;
      ovf_q    <= 1'b0;
      done     <= 1'b0;
      Units    <= '0;
      Tens     <= '0;
      Hundreds <= '0;
      Zero     <= 1'b0;
      Overflow <= 1'b0;
    end else begin
      done <= 1'b0;
      case (state)
        IDLE: begin
          if (start) begin
            bin_q <= value;
            bcd_q <= '0;
            cnt_q <= '0;
            ovf_q <= overflow_in | (10'(value) > MAX_V);
          end
        end
        SHIFT: begin
          bin_q <= bin_q << 1;
          bcd_q <= bcd_step;
          cnt_q <= cnt_q + 4'd1;
          if (last_step) begin
            done     <= 1'b1;
            Overflow <= final_ovf;
            Zero     <= (bcd_step == 10'd0) && !final_ovf;
            if (final_ovf) begin
              Units    <= '0;
              Tens     <= '0;
              Hundreds <= '0;
            end else begin
              Units    <= bcd_step[3:0];
              Tens     <= bcd_step[7:4];
              Hundreds <= bcd_step[9:8];
            end
          end
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_binary_to_bcd_digits.sv
// Bench for binary_to_bcd_digits: directed and random conversions on a MAX_VALUE=255
// instance and a MAX_VALUE=199 instance, checked against an arithmetic decimal model.
module tb_binary_to_bcd_digits;

  localparam int W  = 12;   // packed expectation {units, tens, hundreds, zero, ovf}
  localparam int NB = 8;

  // Clock / reset
  logic clock = 1'b0;
  logic reset = 1'b1;
  always #5 clock = ~clock;

  logic          start    [2];
  logic [NB-1:0] value    [2];
  logic          ovf_in   [2];
  logic          busy     [2];
  logic          done     [2];
  logic [3:0]    units    [2];
  logic [3:0]    tens     [2];
  logic [1:0]    hundreds [2];
  logic          zero     [2];
  logic          overflow [2];
  logic          dbg      [2];

  binary_to_bcd_digits #(.WIDTH(8), .MAX_VALUE(255)) u_dut (
    .clock(clock), .reset(reset), .start(start[0]), .value(value[0]),
    .overflow_in(ovf_in[0]), .busy(busy[0]), .done(done[0]), .Units(units[0]),
    .Tens(tens[0]), .Hundreds(hundreds[0]), .Zero(zero[0]), .Overflow(overflow[0]),
    .debug_state(dbg[0])
  );

  binary_to_bcd_digits #(.WIDTH(8), .MAX_VALUE(199)) u_dut199 (
    .clock(clock), .reset(reset), .start(start[1]), .value(value[1]),
    .overflow_in(ovf_in[1]), .busy(busy[1]), .done(done[1]), .Units(units[1]),
    .Tens(tens[1]), .Hundreds(hundreds[1]), .Zero(zero[1]), .Overflow(overflow[1]),
    .debug_state(dbg[1])
  );

  int checks   = 0;
  int failures = 0;
  logic [W-1:0] exp_q[$];

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  // Reference: decimal digits by division, flags from the display rules.
  function automatic logic [W-1:0] model(input int v, input bit oi, input int maxv);
    bit ovf;
    int u, t, h;
    ovf = oi || (v > maxv);
    u = ovf ? 0 : v % 10;
    t = ovf ? 0 : (v / 10) % 10;
    h = ovf ? 0 : v / 100;
    return {4'(u), 4'(t), 2'(h), 1'(!ovf && v == 0), 1'(ovf)};
  endfunction

  function automatic logic [W-1:0] observed(input int d);
    return {units[d], tens[d], hundreds[d], zero[d], overflow[d]};
  endfunction

  // Driver + scoreboard: one conversion; optional ignored start pulse after edge poke_at.
  task automatic run_conv(input int d, input int v, input bit oi, input int poke_at,
                          input string tag);
    int busy_cnt;
    int done_cnt;
    bit got;
    logic [W-1:0] exp;
    exp_q.push_back(model(v, oi, d == 0 ? 255 : 199));
    @(negedge clock);
    start[d]  = 1'b1;
    value[d]  = NB'(v);
    ovf_in[d] = oi;
    @(negedge clock);
    start[d]  = 1'b0;
    value[d]  = NB'($urandom);
    ovf_in[d] = 1'($urandom);
    busy_cnt = 0;
    got = 0;
    for (int i = 0; i < 20 && !got; i++) begin
      if (busy[d]) busy_cnt++;
      if (done[d]) got = 1;
      else begin
        if (i == poke_at) begin
          start[d] = 1'b1;
          value[d] = 8'd11;
        end else begin
          start[d] = 1'b0;
        end
        @(negedge clock);
      end
    end
    start[d] = 1'b0;
    check({tag, "_done_seen"}, 32'(got), 32'd1);
    check({tag, "_busy_cycles"}, 32'(busy_cnt), 32'd8);
    check({tag, "_busy_at_done"}, 32'(busy[d]), 32'd0);
    exp = exp_q.pop_front();
    check({tag, "_result"}, 32'(observed(d)), 32'(exp));
    check({tag, "_zero_ovf_excl"}, 32'(zero[d] & overflow[d]), 32'd0);
    done_cnt = 0;
    for (int i = 0; i < 3; i++) begin
      @(negedge clock);
      if (done[d] || busy[d]) done_cnt++;
    end
    check({tag, "_single_done_idle"}, 32'(done_cnt), 32'd0);
    check({tag, "_hold"}, 32'(observed(d)), 32'(exp));
  endtask

  initial begin
    for (int d = 0; d < 2; d++) begin
      start[d]  = 1'b0;
      value[d]  = '0;
      ovf_in[d] = 1'b0;
    end
    repeat (3) @(negedge clock);
    reset = 1'b0;
    for (int d = 0; d < 2; d++) begin
      check($sformatf("reset_outputs_%0d", d), 32'(observed(d)), 32'd0);
      check($sformatf("reset_busy_done_%0d", d), 32'({busy[d], done[d]}), 32'd0);
    end

    run_conv(0, 137, 1'b0, -1, "v137");
    run_conv(0, 0,   1'b0, -1, "v0");
    run_conv(0, 255, 1'b0, -1, "v255");
    run_conv(1, 200, 1'b0, -1, "max199_v200");
    run_conv(1, 199, 1'b0, -1, "max199_v199");
    run_conv(0, 42,  1'b1, -1, "v42_ovfin");
    run_conv(0, 9,   1'b0, -1, "v9_after_ovf");
    run_conv(0, 0,   1'b1, -1, "v0_ovfin");
    run_conv(0, 99,  1'b0, 2,  "v99_start_ignored");

    // Abort mid-conversion with an asynchronous reset.
    @(negedge clock);
    start[0] = 1'b1;
    value[0] = 8'd150;
    @(negedge clock);
    start[0] = 1'b0;
    repeat (3) @(negedge clock);
    check("pre_abort_busy", 32'(busy[0]), 32'd1);
    #2 reset = 1'b1;
    #1;
    check("abort_outputs", 32'(observed(0)), 32'd0);
    check("abort_busy_done", 32'({busy[0], done[0]}), 32'd0);
    repeat (2) @(negedge clock);
    check("abort_no_done", 32'(done[0]), 32'd0);
    reset = 1'b0;
    repeat (10) @(negedge clock);
    check("abort_stays_idle", 32'({busy[0], done[0], observed(0)}), 32'd0);
    run_conv(0, 150, 1'b0, -1, "v150_after_abort");

    for (int k = 0; k < 24; k++) begin
      int d;
      d = k % 2;
      run_conv(d, int'($urandom_range(0, 255)), ($urandom_range(0, 7) == 0),
               (k % 5 == 0) ? int'($urandom_range(0, 6)) : -1,
               $sformatf("rand%0d", k));
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/binary_to_bcd_digits.md
Name: binary_to_bcd_digits

Overview:
- Sequential binary-to-BCD converter that produces the digit and flag bus consumed by the calculator's seven-segment display decoder: Units, Tens, Hundreds, Zero and Overflow.
- Sits between the ALU result register and the display decoder.
- Converts an unsigned binary result with an iterative shift-and-add-3 (double-dabble) engine, one bit per clock.
- Uses a start/busy/done handshake and holds the last result stable until the next conversion completes.

Parameters:
- WIDTH, 8, bit width of the binary input. Legal range 4..8.
- MAX_VALUE, 255, largest displayable value. Any input above it is reported as Overflow. Must be at most 2^WIDTH-1 and at most 299.

Ports:
- clock  input  1  system clock; all state updates on the rising edge.
- reset  input  1  asynchronous, active-high reset.
- start  input  1  conversion request; sampled only in IDLE.
- value  input  WIDTH  unsigned binary result from the ALU; sampled on the accepting edge only.
- overflow_in  input  1  ALU overflow/carry flag; sampled with value.
- busy  output  1  high while a conversion is in progress.
- done  output  1  one-cycle pulse when the output digits and flags update.
- Units  output  4  BCD units digit, 0..9.
- Tens  output  4  BCD tens digit, 0..9.
- Hundreds  output  2  hundreds digit, 0..2. Encoding is 00 for 0, 01 for 1, 10 for 2; 11 is never driven.
- Zero  output  1  result equals zero and no overflow.
- Overflow  output  1  overflow_in was set, or value > MAX_VALUE.

Behaviour:
- Reset (asynchronous, active-high), state is IDLE and:
  - busy=0, done=0.
  - Units=0, Tens=0, Hundreds=0.
  - Zero=0, Overflow=0.
  - Shift register and bit counter are cleared.
- Reset asserted mid-conversion aborts it immediately. No done pulse is produced, outputs go to their reset values, and no partial result is ever driven.
- FSM has two states, IDLE and SHIFT.
- IDLE:
  - On an edge with start=1: load value into the binary shift register and clear the BCD scratch register (10 bits: H[1:0], T[3:0], U[3:0]).
  - Counter=0.
  - Latch ovf = overflow_in OR (value > MAX_VALUE).
  - busy goes to 1 and the FSM moves to SHIFT.
  - start=0: remain in IDLE; outputs hold.
- SHIFT, one iteration per edge:
  - Each BCD nibble U and T that is 5 or more gets 3 added.
  - Then shift {H,T,U,bin} left by one bit.
  - Counter increments.
- On the WIDTH-th SHIFT edge:
  - Register the final digits into Units/Tens/Hundreds.
  - Set Overflow=ovf and Zero = (final value == 0) AND NOT ovf.
  - Pulse done=1 and set busy=0, then return to IDLE.
  - done deasserts on the following edge.
- Latency: done is high during cycle WIDTH+1 after the accepting edge (8 SHIFT edges for WIDTH=8). The earliest next accept is the edge on which done is high.
- Overflow result: Units=0, Tens=0, Hundreds=0, Overflow=1, Zero=0, regardless of the computed digits. The display decoder renders its overflow pattern from the flag.
- start while busy=1 is ignored, not queued. Changes to value or overflow_in during SHIFT have no effect.
- Outputs change only on the done edge or on reset. They are never glitched by intermediate iterations.
- Hundreds saturation: never reached given the MAX_VALUE constraint. Any computed hundreds value of 3 or more is treated as overflow.
- Simultaneous Zero and Overflow cannot occur.

Test Plan:
- Reset, then start with value=137, overflow_in=0 -> after 8 SHIFT edges, done pulses for one cycle; Units=7, Tens=3, Hundreds=01, Zero=0, Overflow=0; busy high for exactly 8 cycles.
- value=0 -> done; Units=Tens=0, Hundreds=00, Zero=1, Overflow=0.
- value=255 with MAX_VALUE=255 -> Units=5, Tens=5, Hundreds=10. Then with MAX_VALUE=199 and value=200 -> Overflow=1, digits all 0, Zero=0.
- value=42 with overflow_in=1 -> Overflow=1, Zero=0, digits 0. Next conversion of value=9 with overflow_in=0 -> Units=9, Overflow cleared.
- Start value=99; at SHIFT edge 3, pulse start with value=11 and change value -> ignored; result is Units=9, Tens=9, Hundreds=00, with one done pulse only.
- Start value=150; assert reset at SHIFT edge 4 -> outputs immediately 0, busy=0, no done pulse. After release, start value=150 -> Units=0, Tens=5, Hundreds=01.
